// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multi-cycle RV32I core
// Sequences fetch/decode/execute/memory/writeback and counts fetched instructions.
// Ports:
//   clk, reset (async, active-high)
//   op, funct3, zero    : instruction opcode, branch sense, ALU zero flag
//   PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp : datapath controls
//   state               : current state (debug)
//   instret             : instructions fetched since reset (wraps)
module multicycle_control_fsm #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  output logic               PCwrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instret
);
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 0,
    DECODE   = 1,
    MEMADR   = 2,
    MEMREAD  = 3,
    MEMWB    = 4,
    MEMWRITE = 5,
    EXECUTER = 6,
    EXECUTEI = 7,
    ALUWB    = 8,
    JAL      = 9,
    BEQ      = 10
  } state_t;
  state_t cur, nxt;
  logic pc_update, branch;
  assign state = cur;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur     <= FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH) instret <= instret + CNT_W'(1);
    end
  always_comb begin
    nxt       = FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (cur)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        nxt       = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        nxt = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
              (op == 7'b0110011) ? EXECUTER :
              (op == 7'b0010011) ? EXECUTEI :
              (op == 7'b1101111) ? JAL :
              (op == 7'b1100011) ? BEQ : FETCH;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt     = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        nxt    = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        nxt       = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    // funct3[0] inverts the sense so one state serves both beq and bne
    PCwrite = pc_update | (branch & (zero ^ funct3[0]));
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic [31:0] instret;
  logic       s_PCwrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_RegWrite;
  logic [1:0] s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ALUOp;
  logic [3:0] s_state;
  logic [2:0] s_instret;
  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .PCwrite(PCwrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .instret(instret)
  );
  multicycle_control_fsm #(.STATE_W(4), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .PCwrite(s_PCwrite), .AdrSrc(s_AdrSrc), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .RegWrite(s_RegWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
    .ALUOp(s_ALUOp), .state(s_state), .instret(s_instret)
  );
  wire [12:0] outs = {PCwrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  // {PCwrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp} straight from the state table
  function automatic logic [12:0] exp_outs(input int s, input logic tk);
    case (s)
      0:  return 13'b1_0_0_1_0_10_00_10_00;
      1:  return 13'b0_0_0_0_0_00_01_01_00;
      2:  return 13'b0_0_0_0_0_00_10_01_00;
      3:  return 13'b0_1_0_0_0_00_00_00_00;
      4:  return 13'b0_0_0_0_1_01_00_00_00;
      5:  return 13'b0_1_1_0_0_00_00_00_00;
      6:  return 13'b0_0_0_0_0_00_10_00_10;
      7:  return 13'b0_0_0_0_0_00_10_01_10;
      8:  return 13'b0_0_0_0_1_00_00_00_00;
      9:  return 13'b1_0_0_0_0_00_01_10_00;
      10: return {tk, 12'b0_0_0_0_00_10_00_01};
      default: return 13'b0;
    endcase
  endfunction
  // Whole-instruction state trace as listed per instruction class
  function automatic void trace_of(input logic [6:0] o, output int seq[$]);
    case (o)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 8};
      7'b0010011: seq = '{0, 1, 7, 8};
      7'b1101111: seq = '{0, 1, 9, 8};
      7'b1100011: seq = '{0, 1, 10};
      default:    seq = '{0, 1};
    endcase
  endfunction
  // Starts before the edge that leaves FETCH; ends on the negedge before the next FETCH edge.
  // zmode: 0/1 force zero, 2 randomize it each cycle.
  task automatic do_instr(input string name, input logic [6:0] o, input logic [2:0] f3, input int zmode);
    int seq[$];
    trace_of(o, seq);
    foreach (seq[i]) begin
      op = o;
      funct3 = f3;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      n_checks += 4;
      if (state !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL %s state step %0d: got %0d expected %0d", name, i, state, seq[i]);
      end
      if (outs !== exp_outs(seq[i], zero ^ f3[0])) begin
        n_fail++;
        $display("FAIL %s outputs step %0d: got %b expected %b", name, i, outs, exp_outs(seq[i], zero ^ f3[0]));
      end
      if (instret !== 32'(exp_cnt)) begin
        n_fail++;
        $display("FAIL %s instret step %0d: got %0d expected %0d", name, i, instret, exp_cnt);
      end
      if (s_instret !== 3'(exp_cnt % 8)) begin
        n_fail++;
        $display("FAIL %s instret_wrap step %0d: got %0d expected %0d", name, i, s_instret, exp_cnt % 8);
      end
      if (seq[i] == 0) exp_cnt++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_checks += 3;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", state);
    end
    if (instret !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_instret: got %0d expected 0", instret);
    end
    if (outs !== exp_outs(0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs, exp_outs(0, 1'b0));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0d expected 0", state);
    end
    reset = 1'b0;
    exp_cnt = 0;
  endtask
  task automatic test_lw;
    do_instr("lw", 7'b0000011, 3'b010, 2);
  endtask
  task automatic test_sw;
    do_instr("sw", 7'b0100011, 3'b010, 2);
  endtask
  task automatic test_branch;
    do_instr("beq_z1", 7'b1100011, 3'b000, 1);
    do_instr("beq_z0", 7'b1100011, 3'b000, 0);
    do_instr("bne_z1", 7'b1100011, 3'b001, 1);
    do_instr("bne_z0", 7'b1100011, 3'b001, 0);
  endtask
  task automatic test_jal;
    do_instr("jal", 7'b1101111, 3'b000, 2);
  endtask
  task automatic test_alu;
    do_instr("rtype", 7'b0110011, 3'b000, 2);
    do_instr("itype", 7'b0010011, 3'b111, 2);
  endtask
  task automatic test_illegal;
    do_instr("illegal", 7'b1111111, 3'b000, 2);
  endtask
  task automatic test_back_to_back;
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011, 7'b0000000, 7'b1111111};
    for (int k = 0; k < 60; k++) begin
      int r = $urandom_range(0, 8);
      logic [6:0] o = (r == 8) ? 7'($urandom) : ops[r];
      do_instr("random", o, 3'($urandom), 2);
    end
  endtask
  task automatic test_reset_midway;
    int steps[4] = '{0, 1, 2, 3};
    op = 7'b0000011;
    funct3 = 3'b010;
    foreach (steps[i]) begin
      #1;
      n_checks++;
      if (state !== 4'(steps[i])) begin
        n_fail++;
        $display("FAIL midreset_lead step %0d: got %0d expected %0d", i, state, steps[i]);
      end
      @(negedge clk);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks += 5;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got %0d expected 0", state);
    end
    if (instret !== 32'd0 || s_instret !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_instret: got %0d/%0d expected 0", instret, s_instret);
    end
    if (IRWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_irwrite: got %b expected 1", IRWrite);
    end
    if (AdrSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_adrsrc: got %b expected 0", AdrSrc);
    end
    if (PCwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pcwrite: got %b expected 1", PCwrite);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_release_state: got %0d expected 1", state);
    end
    if (instret !== 32'd1) begin
      n_fail++;
      $display("FAIL midreset_release_instret: got %0d expected 1", instret);
    end
    op = 7'b1111111;
    @(negedge clk);
    @(negedge clk);
    exp_cnt = 1;
    do_instr("after_reset", 7'b0000011, 3'b010, 2);
  endtask
  initial begin
    test_reset;
    test_lw;
    test_sw;
    test_branch;
    test_jal;
    test_alu;
    test_illegal;
    test_back_to_back;
    test_reset_midway;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine of the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the PCwrite enable and next-PC source selection consumed by the PC register directly downstream, along with all datapath mux selects and write enables. It also keeps a retired-instruction counter.

Parameters:
STATE_W, 4, width of the state register / state debug output
CNT_W, 32, width of the instret counter

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
op  in  7  opcode field of the instruction register (instr[6:0])
funct3  in  3  instr[14:12]; used only for the branch sense
zero  in  1  ALU zero flag, valid combinationally in the BEQ state
PCwrite  out  1  PC register load enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register (and OldPC) load enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A
ALUSrcB  out  2  00 = rs2 register B, 01 = ImmExt, 10 = constant 4
ALUOp  out  2  00 = add, 01 = subtract, 10 = decode funct fields
state  out  STATE_W  current state encoding, for debug and verification
instret  out  CNT_W  count of instructions fetched since reset

Behaviour:
- Reset is asynchronous and active-high. On assertion, with no clock edge needed: state = FETCH and instret = 0. Outputs immediately take their FETCH values. Reset mid-instruction abandons that instruction.
- Outputs are Moore (decoded from state only), except PCwrite. PCwrite = PCUpdate | (Branch & taken).
- taken = zero ^ funct3[0], so beq (000) and bne (001) are both supported.
- Every output not listed for a state is 0.
- State encodings, per-state outputs and transitions:
  - 0 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - 1 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next, by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH (treated as a NOP; no writes)
  - 2 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - 3 MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - 4 MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - 5 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
  - 6 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - 7 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - 8 ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - 9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - 10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - Encodings 11-15 are unreachable. If entered, outputs are all 0 and the next state is FETCH.
- Cycle counts per instruction:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type ALU: 4 cycles
  - jal: 4 cycles
  - branch: 3 cycles
  - illegal op: 2 cycles
- op and funct3 are sampled only in DECODE, MEMADR and BEQ. The instruction register is stable there because IRWrite is high only in FETCH.
- instret increments by 1 on each rising edge where state = FETCH. It wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then lw (op=0000011) -> state trace 0,1,2,3,4,0; PCwrite=1 only in FETCH; RegWrite=1 only in state 4 with ResultSrc=01; instret=1 on re-entering FETCH.
- sw (op=0100011) -> trace 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; RegWrite never high.
- beq with funct3=000: zero=1 -> PCwrite=1 in state 10; zero=0 -> PCwrite=0. Repeat with funct3=001 -> the opposite results.
- jal (op=1101111) -> trace 0,1,9,8,0; PCwrite=1 in states 0 and 9; ALUSrcA=01 and ALUSrcB=10 in state 9; RegWrite=1 in state 8.
- Illegal op=1111111 -> trace 0,1,0; MemWrite and RegWrite stay 0; instret +2 over the two fetches.
- Assert reset between edges while in MEMREAD -> state=0, instret=0, IRWrite=1, AdrSrc=0 before the next clock edge. Release reset -> DECODE on the next edge.
